ahb2apb_bridge_mslv: RTL and testbench
======================================

Name: ahb2apb_bridge_mslv

Overview:
- Parametrised AHB-Lite to APB bridge; successor to the fixed two-select bridge.
- Supports NUM_SLAVES APB peripherals (GPIO, timers, UART) with address decode.
- Honours per-slave PREADY wait states and maps PSLVERR and unmapped addresses to a two-cycle AHB ERROR response.
- Sits between the AHB control unit and the APB peripheral cluster in the SoC top.

Parameters:
- NUM_SLAVES, 4, number of APB slaves (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DEC_LSB, 12, lowest HADDR bit of the slave index field; index = iHADDR[DEC_LSB +: clog2(NUM_SLAVES)] (1 bit when NUM_SLAVES=1).
- DEC_MSB_CHK, 1, when 1 the HADDR bits above the index field must be zero, otherwise the access is unmapped.
- TIMEOUT_CYC, 255, ACCESS-phase timeout in cycles; used only with APB_TIMEOUT_EN.

Ports:
- iHCLK  in  1  clock, AHB and APB share it.
- iHRESET  in  1  synchronous active-high reset.
- iHSEL  in  1  bridge selected.
- iHTRANS  in  2  AHB transfer type.
- iHSIZE  in  3  transfer size; accepted, not used.
- iHWRITE  in  1  write/read.
- iHADDR  in  ADDR_W  address.
- iHWDATA  in  DATA_W  write data, valid in the data phase.
- oHREADY  out  1  transfer done / bridge ready.
- oHRESP  out  2  00 OKAY, 01 ERROR.
- oHRDATA  out  DATA_W  registered read data.
- oPSEL  out  NUM_SLAVES  one-hot slave select.
- oPADDR  out  ADDR_W  APB address.
- oPWRITE  out  1  APB direction.
- oPENABLE  out  1  APB access phase.
- oPWDATA  out  DATA_W  APB write data.
- iPRDATA  in  NUM_SLAVES*DATA_W  packed read data; slave k occupies [k*DATA_W +: DATA_W].
- iPREADY  in  NUM_SLAVES  per-slave ready.
- iPSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Clock and reset: single clock iHCLK; reset iHRESET is synchronous and active-high.
- Reset values: state IDLE, oHREADY=1, oHRESP=OKAY, all other outputs 0.
- Accept condition: iHSEL && iHTRANS[1] (NONSEQ/SEQ) && oHREADY. On accept, register HADDR, HWRITE, slave index and range-check result.
- IDLE/BUSY transfers: zero-wait OKAY, no APB activity.
- State machine: IDLE, WDATA, SETUP, ACCESS, DONE, ERR1, ERR2.
  - IDLE/DONE on accept: mapped write -> WDATA; mapped read -> SETUP; unmapped -> ERR1.
  - IDLE/DONE with no accept -> IDLE.
  - WDATA: capture iHWDATA into oPWDATA -> SETUP.
  - SETUP: oPSEL[idx]=1, oPENABLE=0, oPADDR/oPWRITE stable -> ACCESS.
  - ACCESS: oPSEL[idx]=1, oPENABLE=1. Holds while iPREADY[idx]=0. On iPREADY[idx]=1:
    - iPSLVERR[idx]=1 -> ERR1.
    - else capture iPRDATA slice (reads only) into oHRDATA -> DONE.
    - oPSEL/oPENABLE drop the cycle after completion.
  - DONE: oHREADY=1, oHRESP=OKAY.
  - ERR1: oHREADY=0, oHRESP=ERROR -> ERR2.
  - ERR2: oHREADY=1, oHRESP=ERROR; no accept in ERR2 -> IDLE.
- oHREADY is 0 in WDATA, SETUP, ACCESS and ERR1.
- Latency, accept to HREADY=1 with zero-wait slave: read 3 cycles (SETUP, ACCESS, DONE); write 4 cycles. Each PREADY-low cycle adds 1.
- Back-to-back: an accept in DONE starts the next access with no idle cycle.
- Stability: oPADDR, oPWRITE and oPWDATA are held from SETUP through ACCESS completion.
- Outside SETUP/ACCESS: oPSEL=0 and oPENABLE=0.
- Unmapped access (index>=NUM_SLAVES or nonzero high bits when DEC_MSB_CHK=1): no PSEL is ever asserted.
- iPREADY/iPSLVERR of unselected slaves are ignored.
- Reset mid-transfer: next cycle returns to IDLE, PSEL/PENABLE are 0 and oHREADY is 1; the aborted transfer gets no response.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined: a counter clears on entering ACCESS and increments each ACCESS cycle with PREADY low. When the count reaches TIMEOUT_CYC, PSEL and PENABLE deassert and the state goes to ERR1.
- Not defined: ACCESS waits indefinitely and no counter logic exists.

Decomposition:
- Package ahb_apb_pkg: HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes (OKAY/ERROR), bridge state enum.
- Sub-module apb_slave_decode (combinational): address -> slave index, one-hot select and mapped flag, parametrised on NUM_SLAVES/DEC_LSB/DEC_MSB_CHK.
- The PRDATA mux stays inline.

Test Plan:
- Read slave 1 at 0x0000_1004, zero-wait, PRDATA1=0xA5A5_0001 -> PSEL=0010 for 2 cycles, PENABLE in the second; HREADY=1 on the third cycle with HRDATA=0xA5A5_0001 and HRESP=OKAY.
- Write 0x0000_00F0 to 0x0000_0000 with slave 0 holding PREADY low 3 cycles -> PWDATA=0xF0 from SETUP on, ACCESS lasts 4 cycles, HREADY low for 6 cycles total.
- Read slave 2 with PSLVERR=1 at PREADY -> ERR1 (HREADY=0, HRESP=01) then ERR2 (HREADY=1, HRESP=01), no HRDATA update.
- Access 0x0000_5000 with NUM_SLAVES=4 -> no PSEL ever, two-cycle ERROR.
- Back-to-back read slave 0 then write slave 3 -> second accept in DONE, PSEL=1000 in SETUP two cycles later, no IDLE gap.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=8, PREADY held low -> PSEL drops after 8 ACCESS cycles and ERROR is returned; iHRESET pulsed during ACCESS -> IDLE next cycle.

Source files
------------

// File: rtl/ahb2apb_bridge_mslv_pkg.sv
// Shared AHB/APB codes and bridge state encoding for the multi-slave AHB-Lite to APB bridge.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WDATA  = 3'd1;
    localparam state_t ST_SETUP  = 3'd2;
    localparam state_t ST_ACCESS = 3'd3;
    localparam state_t ST_DONE   = 3'd4;
    localparam state_t ST_ERR1   = 3'd5;
    localparam state_t ST_ERR2   = 3'd6;

    // Width of the slave index field; a single slave still decodes one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_mslv_if.sv
// AHB-Lite slave side and APB master side of the bridge, grouped as one bus bundle.
interface ahb2apb_bridge_mslv_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    logic                         iHSEL;
    logic [1:0]                   iHTRANS;
    logic [2:0]                   iHSIZE;
    logic                         iHWRITE;
    logic [ADDR_W-1:0]            iHADDR;
    logic [DATA_W-1:0]            iHWDATA;
    logic                         oHREADY;
    logic [1:0]                   oHRESP;
    logic [DATA_W-1:0]            oHRDATA;
    logic [NUM_SLAVES-1:0]        oPSEL;
    logic [ADDR_W-1:0]            oPADDR;
    logic                         oPWRITE;
    logic                         oPENABLE;
    logic [DATA_W-1:0]            oPWDATA;
    logic [NUM_SLAVES*DATA_W-1:0] iPRDATA;
    logic [NUM_SLAVES-1:0]        iPREADY;
    logic [NUM_SLAVES-1:0]        iPSLVERR;

    modport slave (
        input  iHSEL, iHTRANS, iHSIZE, iHWRITE, iHADDR, iHWDATA,
        output oHREADY, oHRESP, oHRDATA,
        output oPSEL, oPADDR, oPWRITE, oPENABLE, oPWDATA,
        input  iPRDATA, iPREADY, iPSLVERR
    );

    modport master (
        output iHSEL, iHTRANS, iHSIZE, iHWRITE, iHADDR, iHWDATA,
        input  oHREADY, oHRESP, oHRDATA,
        input  oPSEL, oPADDR, oPWRITE, oPENABLE, oPWDATA,
        output iPRDATA, iPREADY, iPSLVERR
    );
endinterface

// File: rtl/ahb2apb_bridge_mslv_decode.sv
// Combinational APB slave decode: address -> slave index, one-hot select and mapped flag.
module apb_slave_decode
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DEC_LSB     = 12,
    parameter int DEC_MSB_CHK = 1
) (
    input  logic [ADDR_W-1:0]                addr,
    output logic [idx_width(NUM_SLAVES)-1:0] idx,
    output logic [NUM_SLAVES-1:0]            sel,
    output logic                             mapped
);
    localparam int IDX_W  = idx_width(NUM_SLAVES);
    localparam int HI_LSB = DEC_LSB + IDX_W;

    logic [ADDR_W-1:0] hi;
    logic              hi_ok;
    logic              in_range;
    logic              unused_low;

    always_comb begin
        idx      = addr[DEC_LSB +: IDX_W];
        hi       = addr >> HI_LSB;
        hi_ok    = (DEC_MSB_CHK == 0) || (hi == '0);
        // Non-power-of-two slave counts leave index codes with no peripheral behind them.
        in_range = (32'(idx) < NUM_SLAVES);
        mapped   = hi_ok && in_range;
        sel      = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            sel[k] = mapped && (32'(idx) == k);
        end
    end

    assign unused_low = ^addr[DEC_LSB-1:0];
endmodule

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-Lite to APB bridge for NUM_SLAVES peripherals with wait states and ERROR mapping.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module ahb2apb_bridge_mslv
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEC_LSB     = 12,
    parameter int DEC_MSB_CHK = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                   iHCLK,
    input logic                   iHRESET,
    ahb2apb_bridge_mslv_if.slave  bus
);
    localparam int IDX_W = idx_width(NUM_SLAVES);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      idx_q;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [IDX_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_mapped;
    logic                  accept;
    logic                  pready;
    logic                  pslverr;
    logic                  timeout;
    logic [DATA_W-1:0]     rd_slice;
    logic                  unused_hsize;

    apb_slave_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .ADDR_W      (ADDR_W),
        .DEC_LSB     (DEC_LSB),
        .DEC_MSB_CHK (DEC_MSB_CHK)
    ) u_decode (
        .addr   (bus.iHADDR),
        .idx    (dec_idx),
        .sel    (dec_sel),
        .mapped (dec_mapped)
    );

    // Only IDLE and DONE take a new address phase; anything offered during ERR2 is dropped.
    assign accept = bus.iHSEL
                 && (bus.iHTRANS == HTRANS_NONSEQ || bus.iHTRANS == HTRANS_SEQ)
                 && (state == ST_IDLE || state == ST_DONE);

    always_comb begin
        rd_slice = bus.iPRDATA[int'(idx_q)*DATA_W +: DATA_W];
        pready   = bus.iPREADY[idx_q];
        pslverr  = bus.iPSLVERR[idx_q];
    end

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge iHCLK) begin
        if (iHRESET) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= '0;
        end else if (state == ST_ACCESS && !pready) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th stalled ACCESS cycle so PSEL drops right after it.
    assign timeout = (state == ST_ACCESS) && !pready && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (!accept)          state_nxt = ST_IDLE;
                else if (!dec_mapped) state_nxt = ST_ERR1;
                else if (bus.iHWRITE) state_nxt = ST_WDATA;
                else                  state_nxt = ST_SETUP;
            end
            ST_WDATA:  state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (timeout)     state_nxt = ST_ERR1;
                else if (pready) state_nxt = pslverr ? ST_ERR1 : ST_DONE;
            end
            ST_ERR1:   state_nxt = ST_ERR2;
            ST_ERR2:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iHCLK) begin
        if (iHRESET) begin
            state       <= ST_IDLE;
            idx_q       <= '0;
            sel_q       <= '0;
            bus.oPADDR  <= '0;
            bus.oPWRITE <= 1'b0;
            bus.oPWDATA <= '0;
            bus.oHRDATA <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus.oPADDR  <= bus.iHADDR;
                bus.oPWRITE <= bus.iHWRITE;
                idx_q       <= dec_idx;
                sel_q       <= dec_sel;
            end
            if (state == ST_WDATA) begin
                bus.oPWDATA <= bus.iHWDATA;
            end
            if (state == ST_ACCESS && pready && !pslverr && !bus.oPWRITE) begin
                bus.oHRDATA <= rd_slice;
            end
        end
    end

    always_comb begin
        bus.oHREADY  = !(state == ST_WDATA || state == ST_SETUP || state == ST_ACCESS || state == ST_ERR1);
        bus.oHRESP   = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        bus.oPSEL    = (state == ST_SETUP || state == ST_ACCESS) ? sel_q : '0;
        bus.oPENABLE = (state == ST_ACCESS);
    end

    assign unused_hsize = ^bus.iHSIZE;
endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Directed bench for ahb2apb_bridge_mslv: transaction-level model expands each transfer into
// per-cycle drives and expected outputs, replayed and compared every cycle.
module tb_ahb2apb_bridge_mslv;
    import ahb_apb_pkg::*;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb2apb_bridge_mslv_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(DW)) bus();

    ahb2apb_bridge_mslv #(
        .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(DW), .DEC_LSB(12),
        .DEC_MSB_CHK(1), .TIMEOUT_CYC(TO)
    ) dut (
        .iHCLK   (clk),
        .iHRESET (rst),
        .bus     (bus)
    );

    typedef struct {
        logic          hsel;
        logic [1:0]    htrans;
        logic          hwrite;
        logic [31:0]   haddr;
        logic [31:0]   hwdata;
        logic [NS-1:0] pready;
        logic [NS-1:0] pslverr;
        logic [NS*DW-1:0] prdata;
        logic          hready;
        logic [1:0]    hresp;
        logic [NS-1:0] psel;
        logic          penable;
        logic [31:0]   paddr;
        logic          pwrite;
        logic [31:0]   pwdata;
        logic [31:0]   hrdata;
    } cyc_t;

    cyc_t sched[$];
    int   n_pass = 0;
    int   n_total = 0;

    logic [31:0] m_paddr = '0, m_pwdata = '0, m_hrdata = '0;
    logic        m_pwrite = 1'b0;

    int            st_psel_cyc, st_pen_cyc, st_lo_cyc, st_err_cyc, st_first_s3;
    logic [NS-1:0] st_psel_or;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    endtask

    // Idle bus drives with noisy responses on every slave, and the outputs an idle bridge shows.
    function automatic cyc_t base_rec();
        cyc_t r;
        r.hsel = 1'b0; r.htrans = HTRANS_IDLE; r.hwrite = 1'b0;
        r.haddr = 32'h0; r.hwdata = 32'hDEAD_BEEF;
        r.pready = '1; r.pslverr = '1;
        for (int k = 0; k < NS; k++) r.prdata[k*DW +: DW] = 32'hBAD0_0000 | k;
        r.hready = 1'b1; r.hresp = HRESP_OKAY; r.psel = '0; r.penable = 1'b0;
        r.paddr = m_paddr; r.pwrite = m_pwrite; r.pwdata = m_pwdata; r.hrdata = m_hrdata;
        return r;
    endfunction

    task automatic push_err();
        cyc_t r;
        r = base_rec(); r.hready = 1'b0; r.hresp = HRESP_ERROR; sched.push_back(r);
        r = base_rec(); r.hresp = HRESP_ERROR; sched.push_back(r);
    endtask

    // One AHB transfer: slaves sit at 4 KB windows from address 0, nothing above is mapped.
    task automatic add_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int nwait, input logic err, input logic [31:0] rdata,
                           input bit b2b, input logic [1:0] trans);
        cyc_t r;
        int   idx;
        bit   mapped;
        bit   tmo;
        int   nacc;
        idx    = int'(addr >> 12);
        mapped = (addr < NS * 4096);
        if (b2b && sched.size() > 0) r = sched.pop_back();
        else r = base_rec();
        r.hsel = 1'b1; r.htrans = trans; r.hwrite = wr; r.haddr = addr;
        sched.push_back(r);
        m_paddr = addr; m_pwrite = wr;
        if (!mapped) begin
            push_err();
            return;
        end
        if (wr) begin
            r = base_rec(); r.hready = 1'b0; r.hwdata = wdata; sched.push_back(r);
            m_pwdata = wdata;
        end
        r = base_rec(); r.hready = 1'b0; r.psel[idx] = 1'b1; sched.push_back(r);
        tmo = 0; nacc = nwait + 1;
`ifdef APB_TIMEOUT_EN
        if (nwait >= TO) begin tmo = 1; nacc = TO; end
`endif
        for (int c = 0; c < nacc; c++) begin
            r = base_rec(); r.hready = 1'b0; r.psel[idx] = 1'b1; r.penable = 1'b1;
            r.pready[idx] = (c == nwait); r.pslverr[idx] = err;
            r.prdata[idx*DW +: DW] = rdata;
            sched.push_back(r);
        end
        if (tmo || err) push_err();
        else begin
            if (!wr) m_hrdata = rdata;
            r = base_rec(); sched.push_back(r);
        end
    endtask

    task automatic apply(input cyc_t r);
        bus.iHSEL = r.hsel; bus.iHTRANS = r.htrans; bus.iHWRITE = r.hwrite;
        bus.iHADDR = r.haddr; bus.iHWDATA = r.hwdata; bus.iHSIZE = 3'b010;
        bus.iPREADY = r.pready; bus.iPSLVERR = r.pslverr; bus.iPRDATA = r.prdata;
    endtask

    // Replays up to max_n scheduled cycles: check outputs, then drive the cycle's inputs.
    task automatic play(input int max_n);
        cyc_t r;
        int   i;
        st_psel_cyc = 0; st_pen_cyc = 0; st_lo_cyc = 0; st_err_cyc = 0;
        st_first_s3 = -1; st_psel_or = '0; i = 0;
        while (sched.size() > 0 && i < max_n) begin
            r = sched.pop_front();
            @(negedge clk);
            chk("hready",  32'(bus.oHREADY),  32'(r.hready));
            chk("hresp",   32'(bus.oHRESP),   32'(r.hresp));
            chk("psel",    32'(bus.oPSEL),    32'(r.psel));
            chk("penable", 32'(bus.oPENABLE), 32'(r.penable));
            chk("paddr",   bus.oPADDR,        r.paddr);
            chk("pwrite",  32'(bus.oPWRITE),  32'(r.pwrite));
            chk("pwdata",  bus.oPWDATA,       r.pwdata);
            chk("hrdata",  bus.oHRDATA,       r.hrdata);
            if (bus.oPSEL != '0) st_psel_cyc++;
            if (bus.oPENABLE) st_pen_cyc++;
            if (!bus.oHREADY) st_lo_cyc++;
            if (bus.oHRESP == HRESP_ERROR) st_err_cyc++;
            if (bus.oPSEL == 4'b1000 && st_first_s3 < 0) st_first_s3 = i;
            st_psel_or |= bus.oPSEL;
            apply(r);
            i++;
        end
    endtask

    initial begin
        apply(base_rec());
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hready",  32'(bus.oHREADY),  32'd1);
        chk("rst_hresp",   32'(bus.oHRESP),   32'd0);
        chk("rst_psel",    32'(bus.oPSEL),    32'd0);
        chk("rst_penable", 32'(bus.oPENABLE), 32'd0);
        chk("rst_paddr",   bus.oPADDR,        32'd0);
        chk("rst_hrdata",  bus.oHRDATA,       32'd0);
        rst = 1'b0;

        // Read slave 1, zero wait.
        add_txn(32'h0000_1004, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_0001, 1'b0, HTRANS_NONSEQ);
        play(1000);
        chk("t1_psel_cycles", 32'(st_psel_cyc), 32'd2);
        chk("t1_psel_value",  32'(st_psel_or),  32'b0010);
        chk("t1_hready_low",  32'(st_lo_cyc),   32'd2);
        chk("t1_hrdata",      bus.oHRDATA,      32'hA5A5_0001);

        // Write slave 0 with three PREADY-low cycles.
        add_txn(32'h0000_0000, 1'b1, 32'h0000_00F0, 3, 1'b0, 32'h0, 1'b0, HTRANS_NONSEQ);
        play(1000);
        chk("t2_access_cycles", 32'(st_pen_cyc), 32'd4);
        chk("t2_hready_low",    32'(st_lo_cyc),  32'd6);
        chk("t2_pwdata",        bus.oPWDATA,     32'h0000_00F0);

        // Read slave 2 ending in PSLVERR.
        add_txn(32'h0000_2000, 1'b0, 32'h0, 1, 1'b1, 32'h1234_5678, 1'b0, HTRANS_NONSEQ);
        play(1000);
        chk("t3_err_cycles", 32'(st_err_cyc), 32'd2);
        chk("t3_hrdata",     bus.oHRDATA,     32'hA5A5_0001);

        // Unmapped: index beyond NUM_SLAVES, then nonzero high bits.
        add_txn(32'h0000_5000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0, HTRANS_NONSEQ);
        add_txn(32'h8000_1000, 1'b1, 32'h55, 0, 1'b0, 32'h0, 1'b0, HTRANS_NONSEQ);
        play(1000);
        chk("t4_psel_cycles", 32'(st_psel_cyc), 32'd0);
        chk("t4_err_cycles",  32'(st_err_cyc),  32'd4);
        chk("t4_hready_low",  32'(st_lo_cyc),   32'd2);

        // BUSY with HSEL: zero-wait OKAY, no APB activity.
        begin
            cyc_t r;
            r = base_rec(); r.hsel = 1'b1; r.htrans = HTRANS_BUSY; r.haddr = 32'h0000_1000;
            sched.push_back(r);
            r = base_rec(); sched.push_back(r);
        end
        play(1000);
        chk("t5_busy_psel",  32'(st_psel_cyc), 32'd0);
        chk("t5_busy_ready", 32'(st_lo_cyc),   32'd0);

        // Back-to-back: read slave 0, then SEQ write slave 3 accepted in DONE.
        add_txn(32'h0000_0010, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, HTRANS_NONSEQ);
        add_txn(32'h0000_3008, 1'b1, 32'h0000_0077, 0, 1'b0, 32'h0, 1'b1, HTRANS_SEQ);
        play(1000);
        chk("t6_first_setup_s3", 32'(st_first_s3), 32'd5);
        chk("t6_psel_union",     32'(st_psel_or),  32'b1001);
        chk("t6_hrdata",         bus.oHRDATA,      32'h0BAD_F00D);

`ifdef APB_TIMEOUT_EN
        add_txn(32'h0000_1000, 1'b0, 32'h0, 50, 1'b0, 32'hFFFF_0000, 1'b0, HTRANS_NONSEQ);
        play(1000);
        chk("t7_timeout_access", 32'(st_pen_cyc), 32'd8);
        chk("t7_timeout_err",    32'(st_err_cyc), 32'd2);
`endif

        // Reset pulsed while slave 1 stalls in ACCESS.
        add_txn(32'h0000_1000, 1'b0, 32'h0, 20, 1'b0, 32'h0, 1'b0, HTRANS_NONSEQ);
        play(4);
        sched.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_hrdata = '0;
        apply(base_rec());
        chk("t8_rst_hready",  32'(bus.oHREADY),  32'd1);
        chk("t8_rst_psel",    32'(bus.oPSEL),    32'd0);
        chk("t8_rst_penable", 32'(bus.oPENABLE), 32'd0);
        chk("t8_rst_hresp",   32'(bus.oHRESP),   32'd0);

        add_txn(32'h0000_3000, 1'b0, 32'h0, 2, 1'b0, 32'h3333_3333, 1'b0, HTRANS_NONSEQ);
        play(1000);
        chk("t8_after_rst_hrdata", bus.oHRDATA, 32'h3333_3333);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
